// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/MEM single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction at a time, and produces the per-stage stall signals.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  state_t state, state_next;
  owner_t owner, owner_next;
  logic   grant;
  logic   capture;

  // Data side wins a tie: it belongs to the older instruction in the pipe.
  always_comb begin
    state_next = state;
    owner_next = owner;
    grant      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req) begin
          owner_next = OWN_D;
          grant      = 1'b1;
          state_next = REQ;
        end else if (if_req) begin
          owner_next = OWN_IF;
          grant      = 1'b1;
          state_next = REQ;
        end
      end
      REQ:  if (mem_ready) state_next = RESP;
      RESP: begin
        if (mem_rvalid) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      mem_req  <= (state_next == REQ);
      if_valid <= capture && (owner == OWN_IF);
      d_valid  <= capture && (owner == OWN_D);
      if (grant) begin
        if (owner_next == OWN_D) begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (capture) begin
        if (owner == OWN_D) d_rdata  <= mem_rdata;
        else                if_rdata <= mem_rdata;
      end
    end
  end

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RV32I pipeline.
- Arbitrates between the two requesters and sequences one transaction at a time over a request/ready plus response-valid memory handshake.
- Routes each response back to its owner.
- Generates the stall signals the hazard logic uses to freeze the requesting stage.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset: asynchronous assert, active-low
- if_req  in  1  fetch request; held with if_addr until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request (load or store); held with d_we, d_addr and d_wdata until d_valid
- d_we  in  1  1 = store (from Mem_Write), 0 = load
- d_addr  in  ADDR_W  data address (ALU result)
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_valid
- d_valid  out  1  one-cycle data completion pulse (also for stores)
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response/write acknowledge this cycle
- mem_rdata  in  DATA_W  response data
- stall_if  out  1  = if_req & ~if_valid (combinational)
- stall_mem  out  1  = d_req & ~d_valid (combinational)

## Operation
- FSM states: IDLE, REQ, RESP, DONE; owner register: OWN_IF or OWN_D.
- **IDLE**
  - If d_req: owner = OWN_D and latch d_we, d_addr, d_wdata. Else if if_req: owner = OWN_IF, latch if_addr, force we = 0.
  - Go to REQ when either request is present; otherwise stay in IDLE.
  - Data wins simultaneous requests: it belongs to the older instruction.
- **REQ**
  - mem_req = 1 with the latched we/addr/wdata driven on mem_* (registered, stable).
  - Stay in REQ until mem_ready = 1, then go to RESP.
- **RESP**
  - mem_req = 0. Wait for mem_rvalid.
  - On mem_rvalid, register mem_rdata into the owner's rdata output and go to DONE.
  - Stores return an ack; the data value is don't-care.
- **DONE**
  - The owner's valid output is high for exactly this cycle; the other valid stays 0.
  - No arbitration happens in DONE: the requester still shows its old req this cycle.
  - Always returns to IDLE.
- Only one transaction is outstanding at a time.
- mem_rvalid is ignored outside RESP, and mem_ready is ignored outside REQ.
- if_rdata and d_rdata hold their last value until overwritten.
- A requester that drops req mid-transaction is a protocol violation. The transaction still completes, and the valid pulse is still produced.

## Timing
- All outputs reset to 0 and the FSM resets to IDLE; owner resets to OWN_IF.
- Reset mid-transaction: the FSM returns to IDLE immediately. Any late mem_rvalid after reset is ignored, per the rule above.
- Zero-wait memory, request first seen in IDLE at cycle 0:
  - mem_req high at cycle 1, mem_rvalid at cycle 2, valid pulse at cycle 3, IDLE at cycle 4.
  - The next mem_req is at cycle 5 at the earliest.
- Each mem_ready wait cycle adds 1 to latency; each cycle of mem_rvalid delay adds 1.
- stall_if and stall_mem follow req and valid in the same cycle, with no register.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum: IDLE=2'd0, REQ=2'd1, RESP=2'd2, DONE=2'd3;
  - the owner encoding: OWN_IF=1'b0, OWN_D=1'b1.
- Single flat module; no sub-module is needed.
- Memory-side and response registers live in the same always block as the FSM.

## Test plan
- **Lone fetch:** if_req=1, if_addr=0x0000_0010, zero-wait memory returning 0x0000_0513. Required: mem_req at cycle 1 with addr 0x10 and mem_we=0; if_valid=1 with if_rdata=0x0000_0513 at cycle 3; stall_if=1 during cycles 0–2.
- **Simultaneous requests:** if_req and d_req (load from 0x100) both in cycle 0. Required: the data transaction is issued first and d_valid pulses at cycle 3; the fetch is issued at cycle 5 and if_valid pulses at cycle 7.
- **Store:** d_req=1, d_we=1, addr 0x200, wdata 0xDEADBEEF, with mem_ready low for 2 cycles. Required: mem_req is held 3 cycles with stable mem_we=1, addr and wdata; d_valid pulses 2 cycles later than the zero-wait case.
- **Back-to-back fetches:** if_req stays high and if_addr advances by 4 after each if_valid. Required: exactly one mem_req per address; no duplicate grant in the DONE cycle; 4-cycle issue spacing.
- **Reset mid-operation:** rst_n low while in RESP, then mem_rvalid arrives 1 cycle after release. Required: all outputs are 0 during reset; no valid pulse; a new if_req is served normally.
- **Spurious response:** mem_rvalid pulsed while in IDLE. Required: no if_valid or d_valid; rdata registers unchanged.
